guard_rule_checker: RTL and testbench
=====================================

// Module: guard_rule_checker
// PURPOSE
//  Consumes a stream of {a,b,c} samples from the random stimulus generator.
//  Over a fixed window of samples, it checks the guarded rule "(a>GUARD_THR || b>GUARD_THR) -> c<=LIMIT" in hardware.
//  It counts attempts, passes and fails, and captures the first failing sample.
//  It sits downstream of the stimulus source and is the synthesizable counterpart of the
//  immediate assert/assume/cover checks: the source produces samples, this block judges them.
// PARAMETERS
//  W          4   width of each sample field a, b, c
//  GUARD_THR  5   guard fires when a>GUARD_THR or b>GUARD_THR (unsigned compare)
//  LIMIT      9   rule passes when c<=LIMIT (unsigned compare)
//  WINDOW     16  samples accepted per run, >=1
//  CNT_W      8   width of the attempt, pass and fail counters
// PORTS
//  clk             in   1      clock; all state updates on posedge
//  rst             in   1      asynchronous, active-high reset
//  start           in   1      begin a run; honoured only in IDLE
//  abort           in   1      end a run early; honoured only in RUN
//  in_valid        in   1      sample valid
//  in_ready        out  1      sample accepted when in_valid && in_ready
//  in_a/in_b/in_c  in   W      sample fields
//  busy            out  1      1 while in RUN
//  done            out  1      one-cycle pulse at the end of a completed window
//  attempt_cnt     out  CNT_W  accepted samples whose guard fired
//  pass_cnt        out  CNT_W  guarded samples that satisfied the rule
//  fail_cnt        out  CNT_W  guarded samples that violated the rule
//  fail_seen       out  1      sticky; set by the first fail of a run
//  ff_a/ff_b/ff_c  out  W      first failing sample of the run
//  ff_idx          out  $clog2(WINDOW+1)  window index (0-based) of the first fail
// BEHAVIOUR
//  Reset: state=IDLE. in_ready, busy, done, fail_seen, all counters, ff_* and the
//   sample index are 0.
//  FSM: IDLE -> RUN when start=1.
//   RUN -> DONE when the accepted sample sits at index WINDOW-1.
//   RUN -> IDLE when abort=1. No done pulse; results are retained.
//   DONE -> IDLE unconditionally after 1 cycle, with done=1 during DONE.
//  IDLE->RUN transition: counters, fail_seen, ff_* and the index all clear to 0 on that edge.
//  In IDLE and DONE, results hold their values until the next start.
//  start is ignored in RUN and DONE. abort is ignored in IDLE and DONE.
//  in_ready = (state==RUN) && !abort. This is combinational, so an abort cycle never
//   accepts a sample.
//  For each accepted sample, all updates are visible the cycle after the handshake:
//   index += 1.
//   guard = (in_a>GUARD_THR)||(in_b>GUARD_THR).
//   If guard: attempt_cnt += 1. Then pass_cnt += 1 if in_c<=LIMIT, else fail_cnt += 1.
//   On a fail with fail_seen==0: capture ff_a/b/c and ff_idx, and set fail_seen.
//  Non-guarded samples still advance the index; they are neither pass nor fail.
//  Counters saturate at 2^CNT_W-1 with no wrap. Invariant: attempt_cnt == pass_cnt + fail_cnt
//   while unsaturated.
//  in_valid=0 in RUN: the FSM waits indefinitely and no state changes.
//  Asynchronous reset mid-run: return to IDLE at once. All outputs go to their reset values,
//   and no done is emitted.
// TESTING
//  1. Reset, start, then 16 samples a=7,b=0,c=3 back-to-back -> attempt=pass=16, fail=0,
//   done pulses 1 cycle after the 16th handshake, busy falls together with the done pulse.
//  2. Samples a=2,b=3,c=15 for 16 cycles -> attempt=pass=fail=0, fail_seen=0, done=1.
//  3. Index 4 = (a=6,b=0,c=12) and index 9 = (a=0,b=8,c=10), others a=0,b=0 ->
//   fail=2, ff_a=6, ff_c=12, ff_idx=4, fail_seen=1.
//  4. abort after 5 guarded-pass samples, with in_valid=1 in the abort cycle -> in_ready=0
//   in that cycle, pass=5, no done, return to IDLE. A new start then clears all counters to 0.
//  5. CNT_W=3, WINDOW=12, all samples guarded-pass -> pass_cnt saturates at 7.
//   Random in_valid gaps -> done still occurs only after the 12th accepted sample.
//  6. Assert rst after 8 samples -> immediate IDLE with all outputs 0.
//   start asserted in the same cycle as rst's release-edge cycle is honoured only once rst=0.

Source files
------------

// File: rtl/guard_rule_checker_if.sv
// Sample stream carrying {a,b,c} from the stimulus source into the rule checker.
// The source drives valid and the fields; the checker answers with ready.
interface guard_rule_checker_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_c;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_c,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_c,
        output in_ready
    );
endinterface

// File: rtl/guard_rule_checker.sv
// Judges the guarded rule (a>GUARD_THR || b>GUARD_THR) -> c<=LIMIT over a window of samples,
// counting attempts/passes/fails and capturing the first failing sample of each run.
module guard_rule_checker #(
    parameter  int W         = 4,
    parameter  int GUARD_THR = 5,
    parameter  int LIMIT     = 9,
    parameter  int WINDOW    = 16,
    parameter  int CNT_W     = 8,
    localparam int IDX_W     = $clog2(WINDOW + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    guard_rule_checker_if.slave  sample_bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     attempt_cnt,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 fail_seen,
    output logic [W-1:0]         ff_a,
    output logic [W-1:0]         ff_b,
    output logic [W-1:0]         ff_c,
    output logic [IDX_W-1:0]     ff_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [W-1:0]     GUARD_V  = W'(GUARD_THR);
    localparam logic [W-1:0]     LIMIT_V  = W'(LIMIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             guard;
    logic             rule_ok;

    // Ready drops combinationally on abort so an abort cycle can never also consume a sample.
    assign sample_bus.in_ready = (state == RUN) && !abort;
    assign accept  = sample_bus.in_valid && sample_bus.in_ready;
    assign guard   = (sample_bus.in_a > GUARD_V) || (sample_bus.in_b > GUARD_V);
    assign rule_ok = (sample_bus.in_c <= LIMIT_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            idx         <= '0;
            attempt_cnt <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            fail_seen   <= 1'b0;
            ff_a        <= '0;
            ff_b        <= '0;
            ff_c        <= '0;
            ff_idx      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        idx         <= '0;
                        attempt_cnt <= '0;
                        pass_cnt    <= '0;
                        fail_cnt    <= '0;
                        fail_seen   <= 1'b0;
                        ff_a        <= '0;
                        ff_b        <= '0;
                        ff_c        <= '0;
                        ff_idx      <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        idx <= idx + 1'b1;
                        // Counters stick at all-ones rather than wrapping.
                        if (guard) begin
                            if (attempt_cnt != CNT_MAX) attempt_cnt <= attempt_cnt + 1'b1;
                            if (rule_ok) begin
                                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
                            end else begin
                                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                                if (!fail_seen) begin
                                    fail_seen <= 1'b1;
                                    ff_a      <= sample_bus.in_a;
                                    ff_b      <= sample_bus.in_b;
                                    ff_c      <= sample_bus.in_c;
                                    ff_idx    <= idx;
                                end
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guard_rule_checker.sv
// Directed and randomized checks of guard_rule_checker against a window-level reference model;
// a second instance with a short window and 3-bit counters exercises saturation.
module tb_guard_rule_checker;

    localparam int W = 4;

    typedef struct {
        int a;
        int b;
        int c;
    } sample_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, abort0 = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0;

    always #5 clk = ~clk;

    guard_rule_checker_if #(.W(W)) if0 ();
    guard_rule_checker_if #(.W(W)) if1 ();

    logic       busy0, done0, seen0;
    logic [7:0] att0, pass0, fail0;
    logic [3:0] ffa0, ffb0, ffc0;
    logic [4:0] ffidx0;

    logic       busy1, done1, seen1;
    logic [2:0] att1, pass1, fail1;
    logic [3:0] ffa1, ffb1, ffc1;
    logic [3:0] ffidx1;

    guard_rule_checker #(.W(W), .GUARD_THR(5), .LIMIT(9), .WINDOW(16), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .sample_bus(if0.slave),
        .busy(busy0), .done(done0), .attempt_cnt(att0), .pass_cnt(pass0), .fail_cnt(fail0),
        .fail_seen(seen0), .ff_a(ffa0), .ff_b(ffb0), .ff_c(ffc0), .ff_idx(ffidx0)
    );

    guard_rule_checker #(.W(W), .GUARD_THR(5), .LIMIT(9), .WINDOW(12), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .sample_bus(if1.slave),
        .busy(busy1), .done(done1), .attempt_cnt(att1), .pass_cnt(pass1), .fail_cnt(fail1),
        .fail_seen(seen1), .ff_a(ffa1), .ff_b(ffb1), .ff_c(ffc1), .ff_idx(ffidx1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state: whether each instance should be running, and the samples it accepted this run.
    bit      run0 = 1'b0, run1 = 1'b0;
    sample_t win0[$];
    sample_t win1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input int a, input int b, input int c);
        if (which == 0) begin
            if0.in_valid = v; if0.in_a = W'(a); if0.in_b = W'(b); if0.in_c = W'(c);
        end else begin
            if1.in_valid = v; if1.in_a = W'(a); if1.in_b = W'(b); if1.in_c = W'(c);
        end
    endtask

    task automatic check_ctrl(input int which, input string tag, input bit e_busy, input bit e_done);
        if (which == 0) begin
            check({tag, "_busy"}, 32'(busy0), 32'(e_busy));
            check({tag, "_done"}, 32'(done0), 32'(e_done));
        end else begin
            check({tag, "_busy"}, 32'(busy1), 32'(e_busy));
            check({tag, "_done"}, 32'(done1), 32'(e_done));
        end
    endtask

    // Expected results are recomputed from scratch over the whole accepted window.
    task automatic expect_results(input int which, input string tag);
        sample_t q[$];
        int sat, att, ps, fl, fa, fb, fc, fidx;
        bit seen;
        logic [31:0] o_att, o_ps, o_fl, o_seen, o_fa, o_fb, o_fc, o_idx;
        if (which == 0) begin
            q = win0; sat = 255;
            o_att = 32'(att0); o_ps = 32'(pass0); o_fl = 32'(fail0); o_seen = 32'(seen0);
            o_fa = 32'(ffa0); o_fb = 32'(ffb0); o_fc = 32'(ffc0); o_idx = 32'(ffidx0);
        end else begin
            q = win1; sat = 7;
            o_att = 32'(att1); o_ps = 32'(pass1); o_fl = 32'(fail1); o_seen = 32'(seen1);
            o_fa = 32'(ffa1); o_fb = 32'(ffb1); o_fc = 32'(ffc1); o_idx = 32'(ffidx1);
        end
        att = 0; ps = 0; fl = 0; fa = 0; fb = 0; fc = 0; fidx = 0; seen = 1'b0;
        foreach (q[i]) begin
            if (q[i].a > 5 || q[i].b > 5) begin
                att++;
                if (q[i].c <= 9) ps++;
                else begin
                    fl++;
                    if (!seen) begin
                        seen = 1'b1; fa = q[i].a; fb = q[i].b; fc = q[i].c; fidx = i;
                    end
                end
            end
        end
        if (att > sat) att = sat;
        if (ps > sat) ps = sat;
        if (fl > sat) fl = sat;
        check({tag, "_attempt"}, o_att, att);
        check({tag, "_pass"}, o_ps, ps);
        check({tag, "_fail"}, o_fl, fl);
        check({tag, "_fail_seen"}, o_seen, 32'(seen));
        check({tag, "_ff_a"}, o_fa, fa);
        check({tag, "_ff_b"}, o_fb, fb);
        check({tag, "_ff_c"}, o_fc, fc);
        check({tag, "_ff_idx"}, o_idx, fidx);
    endtask

    // Called and returns at a falling edge; the rising edge in between is the handshake edge.
    task automatic push(input int which, input logic v, input int a, input int b, input int c);
        bit      exp_rdy, fin;
        logic    obs_rdy;
        sample_t s;
        exp_rdy = (which == 0) ? (run0 && !abort0) : (run1 && !abort1);
        drive(which, v, a, b, c);
        #1;
        obs_rdy = (which == 0) ? if0.in_ready : if1.in_ready;
        check($sformatf("ready_d%0d", which), 32'(obs_rdy), 32'(exp_rdy));
        fin = 1'b0;
        if (v && exp_rdy) begin
            s.a = a; s.b = b; s.c = c;
            if (which == 0) begin
                win0.push_back(s);
                if (win0.size() == 16) begin run0 = 1'b0; fin = 1'b1; end
            end else begin
                win1.push_back(s);
                if (win1.size() == 12) begin run1 = 1'b0; fin = 1'b1; end
            end
        end
        @(negedge clk);
        drive(which, 1'b0, 0, 0, 0);
        check_ctrl(which, $sformatf("push_d%0d", which), (which == 0) ? run0 : run1, fin);
    endtask

    task automatic start_run(input int which);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        if (which == 0) begin
            start0 = 1'b0; run0 = 1'b1; win0.delete();
        end else begin
            start1 = 1'b0; run1 = 1'b1; win1.delete();
        end
        check_ctrl(which, $sformatf("start_d%0d", which), 1'b1, 1'b0);
    endtask

    task automatic abort_run(input int which, input int a, input int b, input int c);
        logic obs_rdy;
        if (which == 0) abort0 = 1'b1; else abort1 = 1'b1;
        drive(which, 1'b1, a, b, c);
        #1;
        obs_rdy = (which == 0) ? if0.in_ready : if1.in_ready;
        check($sformatf("abort_ready_d%0d", which), 32'(obs_rdy), 32'd0);
        @(negedge clk);
        if (which == 0) begin abort0 = 1'b0; run0 = 1'b0; end
        else begin abort1 = 1'b0; run1 = 1'b0; end
        drive(which, 1'b0, 0, 0, 0);
        check_ctrl(which, "abort", 1'b0, 1'b0);
        @(negedge clk);
        check_ctrl(which, "abort_after", 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard_n;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        expect_results(0, "reset0");
        expect_results(1, "reset1");
        check_ctrl(0, "reset0", 1'b0, 1'b0);
        check("reset_ready0", 32'(if0.in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] window of guarded passes");
        start_run(0);
        for (int i = 0; i < 16; i++) push(0, 1'b1, 7, 0, 3);
        expect_results(0, "t1");
        check("t1_pass_const", 32'(pass0), 32'd16);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check_ctrl(0, "t1_start_in_done", 1'b0, 1'b0);
        expect_results(0, "t1_hold");

        $display("[TB] window with no guard firing");
        start_run(0);
        for (int i = 0; i < 16; i++) push(0, 1'b1, 2, 3, 15);
        expect_results(0, "t2");
        @(negedge clk);

        $display("[TB] two fails, first captured");
        start_run(0);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) push(0, 1'b1, 6, 0, 12);
            else if (i == 9) push(0, 1'b1, 0, 8, 10);
            else push(0, 1'b1, 0, 0, int'($urandom_range(0, 15)));
        end
        expect_results(0, "t3");
        check("t3_ff_idx_const", 32'(ffidx0), 32'd4);
        check("t3_fail_const", 32'(fail0), 32'd2);
        @(negedge clk);

        $display("[TB] abort mid-run then restart");
        start_run(0);
        for (int i = 0; i < 5; i++) push(0, 1'b1, 7, 0, 3);
        abort_run(0, 7, 0, 3);
        expect_results(0, "t4");
        start_run(0);
        expect_results(0, "t4_restart");
        abort_run(0, 0, 0, 0);

        $display("[TB] random windows with valid gaps");
        for (int r = 0; r < 3; r++) begin
            start_run(0);
            guard_n = 0;
            while (run0 && guard_n < 200) begin
                push(0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                guard_n++;
            end
            expect_results(0, $sformatf("rand%0d", r));
            @(negedge clk);
        end
        start_run(0);
        for (int i = 0; i < int'($urandom_range(1, 12)); i++)
            push(0, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)));
        abort_run(0, 9, 9, 15);
        expect_results(0, "rand_abort");

        $display("[TB] saturation on short window");
        start_run(1);
        guard_n = 0;
        while (run1 && guard_n < 200) begin
            push(1, $urandom_range(0, 1) != 0, int'($urandom_range(6, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 9)));
            guard_n++;
        end
        expect_results(1, "t5");
        check("t5_pass_sat", 32'(pass1), 32'd7);
        @(negedge clk);

        $display("[TB] reset mid-run");
        start_run(0);
        for (int i = 0; i < 8; i++) push(0, 1'b1, 6, 6, 12);
        #2 rst = 1'b1;
        #1;
        win0.delete(); win1.delete(); run0 = 1'b0; run1 = 1'b0;
        expect_results(0, "t6_rst");
        check_ctrl(0, "t6_rst", 1'b0, 1'b0);
        check("t6_rst_ready", 32'(if0.in_ready), 32'd0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        check_ctrl(0, "t6_start_in_rst", 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        run0 = 1'b1;
        check_ctrl(0, "t6_start_after_rst", 1'b1, 1'b0);
        push(0, 1'b1, 7, 0, 14);
        expect_results(0, "t6_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
